seq_pattern_tx: RTL and testbench

//   Serial pattern transmitter: the sending end of the serial bit-stream interface the 1010 sequence detector consumes.

---
 rtl/seq_pattern_tx.sv | 94 +++++++++
 tb/tb_seq_pattern_tx.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_tx.sv
// rtl/seq_pattern_tx.sv - serial pattern transmitter, MSB-first, repeated back-to-back
module seq_pattern_tx #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_cnt,
  output logic             din,
  output logic             din_valid,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = $clog2(PAT_W);
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(PAT_W - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_n;
  logic [PAT_W-1:0] pat_q, pat_n;
  logic [IDX_W-1:0] idx_q, idx_n;
  logic [CNT_W-1:0] rep_q, rep_n;
  logic             din_n, valid_n, done_n;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      pat_q     <= '0;
      idx_q     <= '0;
      rep_q     <= '0;
      din       <= 1'b0;
      din_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      pat_q     <= pat_n;
      idx_q     <= idx_n;
      rep_q     <= rep_n;
      din       <= din_n;
      din_valid <= valid_n;
      busy      <= (state_n == SHIFT);
      done      <= done_n;
    end
  end

  // rep_q == 0 means continuous; a finite burst ends when bit 0 is sent with rep_q == 1
  always_comb begin
    state_n = state;
    pat_n   = pat_q;
    idx_n   = idx_q;
    rep_n   = rep_q;
    din_n   = 1'b0;
    valid_n = 1'b0;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_n = SHIFT;
          pat_n   = pattern;
          rep_n   = repeat_cnt;
          idx_n   = IDX_MSB;
          din_n   = pattern[PAT_W-1];
          valid_n = 1'b1;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_n = IDLE;
        end else if (idx_q == '0) begin
          if (rep_q == CNT_W'(1)) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            idx_n   = IDX_MSB;
            din_n   = pat_q[PAT_W-1];
            valid_n = 1'b1;
            if (rep_q != '0) rep_n = rep_q - CNT_W'(1);
          end
        end else begin
          idx_n   = idx_q - IDX_W'(1);
          din_n   = pat_q[idx_n];
          valid_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb/tb_seq_pattern_tx.sv - directed self-checking bench for seq_pattern_tx
module tb_seq_pattern_tx;

  logic       clk = 1'b0;
  logic       reset, start, abort;
  logic [3:0] pattern;
  logic [7:0] repeat_cnt;
  logic       din, din_valid, busy, done;

  int passed = 0;
  int total  = 0;
  int det_cnt, done_cnt;
  logic [3:0] hist, exp_pat;

  seq_pattern_tx #(.PAT_W(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .pattern(pattern), .repeat_cnt(repeat_cnt),
    .din(din), .din_valid(din_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0; pattern = 4'b0; repeat_cnt = 8'd0;
    tick(); tick();
    check("rst_din", 8'(din), 8'd0);
    check("rst_valid", 8'(din_valid), 8'd0);
    check("rst_busy", 8'(busy), 8'd0);
    check("rst_done", 8'(done), 8'd0);
    reset = 1'b1;
    tick();

    // single 1010 burst
    pattern = 4'b1010; repeat_cnt = 8'd1; start = 1'b1; exp_pat = 4'b1010;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t1_din%0d", i), 8'(din), 8'(exp_pat[3-i]));
      check($sformatf("t1_valid%0d", i), 8'(din_valid), 8'd1);
      check($sformatf("t1_busy%0d", i), 8'(busy), 8'd1);
      tick();
    end
    check("t1_done", 8'(done), 8'd1);
    check("t1_busy_end", 8'(busy), 8'd0);
    check("t1_valid_end", 8'(din_valid), 8'd0);
    tick();
    check("t1_done_once", 8'(done), 8'd0);

    // three reps into an overlapping 1010 detector
    repeat_cnt = 8'd3; start = 1'b1; hist = 4'b0; det_cnt = 0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      check($sformatf("t2_din%0d", i), 8'(din), 8'(exp_pat[3-(i%4)]));
      check($sformatf("t2_valid%0d", i), 8'(din_valid), 8'd1);
      hist = {hist[2:0], din};
      if (hist == 4'b1010) det_cnt++;
      tick();
    end
    check("t2_done", 8'(done), 8'd1);
    check("t2_detects", 8'(det_cnt), 8'd5);
    tick();

    // start during busy ignored, pattern changes ignored
    repeat_cnt = 8'd2; start = 1'b1; done_cnt = 0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t3_din%0d", i), 8'(din), 8'(exp_pat[3-(i%4)]));
      if (done) done_cnt++;
      if (i == 2) begin start = 1'b1; pattern = 4'b1111; repeat_cnt = 8'd5; end
      if (i == 3) start = 1'b0;
      tick();
    end
    if (done) done_cnt++;
    tick();
    if (done) done_cnt++;
    check("t3_done_cnt", 8'(done_cnt), 8'd1);
    check("t3_idle_busy", 8'(busy), 8'd0);

    // continuous 1100 stopped by abort on the sixth bit
    pattern = 4'b1100; repeat_cnt = 8'd0; start = 1'b1; exp_pat = 4'b1100; done_cnt = 0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t4_din%0d", i), 8'(din), 8'(exp_pat[3-(i%4)]));
      check($sformatf("t4_valid%0d", i), 8'(din_valid), 8'd1);
      if (done) done_cnt++;
      if (i == 5) abort = 1'b1;
      tick();
    end
    abort = 1'b0;
    check("t4_valid_abort", 8'(din_valid), 8'd0);
    check("t4_din_abort", 8'(din), 8'd0);
    check("t4_busy_abort", 8'(busy), 8'd0);
    if (done) done_cnt++;
    tick();
    if (done) done_cnt++;
    check("t4_no_done", 8'(done_cnt), 8'd0);
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("t4_abort_wins", 8'(busy), 8'd0);
    check("t4_abort_wins_valid", 8'(din_valid), 8'd0);

    // reset in mid-burst, then a fresh burst
    pattern = 4'b0110; repeat_cnt = 8'd2; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("t5_din", 8'(din), 8'd0);
    check("t5_valid", 8'(din_valid), 8'd0);
    check("t5_busy", 8'(busy), 8'd0);
    check("t5_done", 8'(done), 8'd0);
    tick();
    pattern = 4'b1011; repeat_cnt = 8'd1; start = 1'b1; exp_pat = 4'b1011;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t5_din%0d", i), 8'(din), 8'(exp_pat[3-i]));
      tick();
    end
    check("t5_done_end", 8'(done), 8'd1);
    tick();

    // start held through the done cycle gives back-to-back bursts
    pattern = 4'b1001; repeat_cnt = 8'd1; start = 1'b1; exp_pat = 4'b1001;
    tick();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t6a_din%0d", i), 8'(din), 8'(exp_pat[3-i]));
      check($sformatf("t6a_valid%0d", i), 8'(din_valid), 8'd1);
      tick();
    end
    check("t6_gap_valid", 8'(din_valid), 8'd0);
    check("t6_gap_done", 8'(done), 8'd1);
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t6b_din%0d", i), 8'(din), 8'(exp_pat[3-i]));
      check($sformatf("t6b_valid%0d", i), 8'(din_valid), 8'd1);
      check($sformatf("t6b_busy%0d", i), 8'(busy), 8'd1);
      tick();
    end
    check("t6_done2", 8'(done), 8'd1);
    tick();
    check("t6_idle", 8'(busy), 8'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
